ai_min_select: RTL and testbench

Decision stage directly downstream of the distance filter in the comparer chain. It consumes one filtered `{label[7:0], distance[23:0]}` word per candidate class and tracks the minimum and second-minimum distance over a frame of `NUM_CLASSES` candidates. At frame end it emits the winning label, its distance, the best-to-runner-up margin and a valid flag. A distance of `24'hFFFFFF` is the filter's rejection marker and never produces a valid winner.

---
 rtl/ai_min_select_if.sv | 24 ++
 rtl/ai_min_select.sv | 111 +++++++++++
 tb/tb_ai_min_select.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ai_min_select_if.sv
// Candidate/result bundle for ai_min_select.
// master drives candidates and frame_clr; slave returns the registered result.
interface ai_min_select_if;
    logic [31:0] data_in;
    logic        data_in_rdy;
    logic        frame_clr;
    logic [7:0]  result_label;
    logic [23:0] result_dist;
    logic [23:0] result_margin;
    logic        result_valid;
    logic        result_rdy;

    modport master (
        output data_in, data_in_rdy, frame_clr,
        input  result_label, result_dist, result_margin,
        input  result_valid, result_rdy
    );

    modport slave (
        input  data_in, data_in_rdy, frame_clr,
        output result_label, result_dist, result_margin,
        output result_valid, result_rdy
    );
endinterface

// File: rtl/ai_min_select.sv
// Min/second-min tracker over NUM_CLASSES candidates per frame.
// Ports: clk, rst (async active-low), bus (slave): candidates in, result out.
module ai_min_select #(
    parameter int NUM_CLASSES = 16
) (
    input logic           clk,
    input logic           rst,
    ai_min_select_if.slave bus
);
    localparam int CW = $clog2(NUM_CLASSES + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);
    localparam logic [23:0] IDLE_D = 24'hFFFFFF;
    localparam logic [7:0]  IDLE_L = 8'hFF;

    logic [23:0]   best_d_q, best_d_d;
    logic [7:0]    best_l_q, best_l_d;
    logic [23:0]   sec_d_q, sec_d_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [7:0]  lbl_q, lbl_d;
    logic [23:0] dist_q, dist_d;
    logic [23:0] mrg_q, mrg_d;
    logic        vld_q, vld_d;
    logic        rdy_q, rdy_d;

    logic [23:0]   bd_b, sd_b, nbd, nsd, cand_d;
    logic [7:0]    bl_b, nbl, cand_l;
    logic [CW-1:0] cnt_b;
    logic          last, win;

    assign cand_d = bus.data_in[23:0];
    assign cand_l = bus.data_in[31:24];

    always_comb begin
        // frame_clr restarts from idle, so a coincident candidate is #0
        bd_b  = bus.frame_clr ? IDLE_D : best_d_q;
        bl_b  = bus.frame_clr ? IDLE_L : best_l_q;
        sd_b  = bus.frame_clr ? IDLE_D : sec_d_q;
        cnt_b = bus.frame_clr ? '0 : cnt_q;

        nbd = bd_b;
        nbl = bl_b;
        nsd = sd_b;
        if (bus.data_in_rdy) begin
            if (cand_d < bd_b) begin
                nsd = bd_b;
                nbd = cand_d;
                nbl = cand_l;
            end else if (cand_d < sd_b) begin
                nsd = cand_d;
            end
        end

        last = bus.data_in_rdy && (cnt_b == LAST);
        win  = (nbd != IDLE_D);

        best_d_d = nbd;
        best_l_d = nbl;
        sec_d_d  = nsd;
        cnt_d    = bus.data_in_rdy ? cnt_b + CW'(1) : cnt_b;

        lbl_d  = lbl_q;
        dist_d = dist_q;
        mrg_d  = mrg_q;
        vld_d  = vld_q;
        rdy_d  = 1'b0;

        if (last) begin
            best_d_d = IDLE_D;
            best_l_d = IDLE_L;
            sec_d_d  = IDLE_D;
            cnt_d    = '0;
            rdy_d    = 1'b1;
            vld_d    = win;
            lbl_d    = win ? nbl : IDLE_L;
            dist_d   = nbd;
            // nsd >= nbd always holds, so no underflow
            mrg_d    = win ? (nsd - nbd) : 24'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_d_q <= IDLE_D;
            best_l_q <= IDLE_L;
            sec_d_q  <= IDLE_D;
            cnt_q    <= '0;
            lbl_q    <= '0;
            dist_q   <= '0;
            mrg_q    <= '0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            best_d_q <= best_d_d;
            best_l_q <= best_l_d;
            sec_d_q  <= sec_d_d;
            cnt_q    <= cnt_d;
            lbl_q    <= lbl_d;
            dist_q   <= dist_d;
            mrg_q    <= mrg_d;
            vld_q    <= vld_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.result_label  = lbl_q;
    assign bus.result_dist   = dist_q;
    assign bus.result_margin = mrg_q;
    assign bus.result_valid  = vld_q;
    assign bus.result_rdy    = rdy_q;
endmodule

// File: tb/tb_ai_min_select.sv
// Directed bench for ai_min_select with NUM_CLASSES=4 and NUM_CLASSES=1.
// Inputs change at negedge+1ns; outputs are sampled there too.
module tb_ai_min_select;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   p4 = 0;
    int   p1 = 0;

    always #5 clk = ~clk;

    ai_min_select_if if4();
    ai_min_select_if if1();

    ai_min_select #(.NUM_CLASSES(4)) u4 (
        .clk(clk), .rst(rst_n), .bus(if4)
    );
    ai_min_select #(.NUM_CLASSES(1)) u1 (
        .clk(clk), .rst(rst_n), .bus(if1)
    );

    always @(negedge clk) begin
        if (if4.result_rdy === 1'b1) p4 = p4 + 1;
        if (if1.result_rdy === 1'b1) p1 = p1 + 1;
    end

    task automatic drv4(input logic v, input logic c,
                        input logic [31:0] w);
        if4.data_in = w;
        if4.data_in_rdy = v;
        if4.frame_clr = c;
        @(negedge clk);
        #1;
    endtask

    task automatic drv1(input logic v, input logic [31:0] w);
        if1.data_in = w;
        if1.data_in_rdy = v;
        if1.frame_clr = 1'b0;
        @(negedge clk);
        #1;
        if1.data_in_rdy = 1'b0;
    endtask

    task automatic test_reset;
        int base;
        // reset state
        total++;
        if ({if4.result_label, if4.result_dist, if4.result_margin,
             if4.result_valid, if4.result_rdy} !== 58'd0)
            $display("FAIL reset4_outs got %h want 0",
                     {if4.result_label, if4.result_dist,
                      if4.result_margin, if4.result_valid,
                      if4.result_rdy});
        else passed++;
        total++;
        if ({if1.result_label, if1.result_dist, if1.result_margin,
             if1.result_valid, if1.result_rdy} !== 58'd0)
            $display("FAIL reset1_outs got %h want 0",
                     {if1.result_label, if1.result_dist,
                      if1.result_margin, if1.result_valid,
                      if1.result_rdy});
        else passed++;
        rst_n = 1'b1;
        drv4(0, 0, 0);
        // full frame so the outputs are non-zero before the next reset
        drv4(1, 0, {8'd9, 24'h000050});
        drv4(1, 0, {8'd8, 24'h000060});
        drv4(1, 0, {8'd7, 24'h000070});
        drv4(1, 0, {8'd6, 24'h000080});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'd9)
            $display("FAIL pre_reset_frame got rdy=%b lbl=%h want 1 09",
                     if4.result_rdy, if4.result_label);
        else passed++;
        // two candidates, then asynchronous reset mid-cycle
        drv4(1, 0, {8'd1, 24'h000001});
        drv4(1, 0, {8'd2, 24'h000002});
        if4.data_in_rdy = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({if4.result_label, if4.result_dist, if4.result_margin,
             if4.result_valid, if4.result_rdy} !== 58'd0)
            $display("FAIL async_reset_outs got %h want 0",
                     {if4.result_label, if4.result_dist,
                      if4.result_margin, if4.result_valid,
                      if4.result_rdy});
        else passed++;
        @(negedge clk);
        #1;
        drv4(0, 0, 0);
        rst_n = 1'b1;
        base = p4;
        drv4(1, 0, {8'd1, 24'h000030});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL rst_no_early1 got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'd2, 24'h000010});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL rst_no_early2 got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'd3, 24'h000020});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL rst_no_early3 got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'd4, 24'h000040});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'd2 ||
            if4.result_dist !== 24'h10 || if4.result_margin !== 24'h10)
            $display("FAIL rst_frame got rdy=%b %h %h %h want 1 02 10 10",
                     if4.result_rdy, if4.result_label,
                     if4.result_dist, if4.result_margin);
        else passed++;
        drv4(0, 0, 0);
        total++;
        if (p4 - base !== 1)
            $display("FAIL rst_pulses got %0d want 1", p4 - base);
        else passed++;
    endtask

    task automatic test_basic;
        drv4(1, 0, {8'd3, 24'h000500});
        drv4(1, 0, {8'd7, 24'h000120});
        drv4(1, 0, {8'd1, 24'h000300});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL basic_early got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'd9, 24'h000200});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'd7 ||
            if4.result_dist !== 24'h120 ||
            if4.result_margin !== 24'hE0 || if4.result_valid !== 1'b1)
            $display("FAIL basic got %b %h %h %h %b want 1 07 120 e0 1",
                     if4.result_rdy, if4.result_label, if4.result_dist,
                     if4.result_margin, if4.result_valid);
        else passed++;
        drv4(0, 0, 0);
        total++;
        if (if4.result_rdy !== 1'b0 || if4.result_label !== 8'd7 ||
            if4.result_dist !== 24'h120)
            $display("FAIL basic_hold got %b %h %h want 0 07 120",
                     if4.result_rdy, if4.result_label, if4.result_dist);
        else passed++;
    endtask

    task automatic test_tie_reject;
        drv4(1, 0, {8'd2, 24'h000100});
        drv4(1, 0, {8'd5, 24'h000100});
        drv4(1, 0, {8'd6, 24'hFFFFFF});
        drv4(1, 0, {8'd8, 24'hFFFFFF});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'd2 ||
            if4.result_dist !== 24'h100 ||
            if4.result_margin !== 24'h0 || if4.result_valid !== 1'b1)
            $display("FAIL tie got %b %h %h %h %b want 1 02 100 0 1",
                     if4.result_rdy, if4.result_label, if4.result_dist,
                     if4.result_margin, if4.result_valid);
        else passed++;
        for (int i = 0; i < 4; i++)
            drv4(1, 0, {8'(i), 24'hFFFFFF});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'hFF ||
            if4.result_dist !== 24'hFFFFFF ||
            if4.result_margin !== 24'h0 || if4.result_valid !== 1'b0)
            $display("FAIL reject got %b %h %h %h %b want 1 ff ffffff 0 0",
                     if4.result_rdy, if4.result_label, if4.result_dist,
                     if4.result_margin, if4.result_valid);
        else passed++;
        drv4(0, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [23:0] d[16];
        logic [7:0]  l[16];
        logic [23:0] s[4];
        logic [23:0] t, eb, es, em;
        logic [7:0]  el;
        logic        ev;
        int base, r;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 6);
            d[i] = (r == 6) ? 24'hFFFFFF : 24'(r) << 8;
            l[i] = 8'(16 + i);
        end
        base = p4;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 4; k++) begin
                if (f >= 2) begin
                    r = $urandom_range(0, 3);
                    for (int g = 0; g < r; g++) drv4(0, 0, 32'hDEADBEEF);
                end
                drv4(1, 0, {l[4*f+k], d[4*f+k]});
                if (k != 3) begin
                    total++;
                    if (if4.result_rdy !== 1'b0)
                        $display("FAIL b2b_early f%0d k%0d got %b want 0",
                                 f, k, if4.result_rdy);
                    else passed++;
                end
            end
            for (int i = 0; i < 4; i++) s[i] = d[4*f+i];
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                    if (s[j] > s[j+1]) begin
                        t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                    end
            eb = s[0];
            es = s[1];
            el = 8'hFF;
            for (int i = 3; i >= 0; i--)
                if (d[4*f+i] == eb) el = l[4*f+i];
            ev = (eb != 24'hFFFFFF);
            if (!ev) el = 8'hFF;
            em = ev ? es - eb : 24'd0;
            total++;
            if (if4.result_rdy !== 1'b1 || if4.result_label !== el ||
                if4.result_dist !== eb || if4.result_margin !== em ||
                if4.result_valid !== ev)
                $display("FAIL b2b_f%0d got %b %h %h %h %b want 1 %h %h %h %b",
                         f, if4.result_rdy, if4.result_label,
                         if4.result_dist, if4.result_margin,
                         if4.result_valid, el, eb, em, ev);
            else passed++;
        end
        drv4(0, 0, 0);
        total++;
        if (p4 - base !== 4)
            $display("FAIL b2b_pulses got %0d want 4", p4 - base);
        else passed++;
    endtask

    task automatic test_frame_clr;
        int base;
        base = p4;
        drv4(1, 0, {8'd1, 24'h000005});
        drv4(1, 0, {8'd2, 24'h000006});
        drv4(1, 1, {8'd4, 24'h000010});
        drv4(1, 0, {8'd5, 24'h000800});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL clr_early1 got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'd6, 24'h000800});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL clr_early2 got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'd7, 24'h000800});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'd4 ||
            if4.result_dist !== 24'h10 || if4.result_margin !== 24'h7F0)
            $display("FAIL clr_data got %b %h %h %h want 1 04 10 7f0",
                     if4.result_rdy, if4.result_label, if4.result_dist,
                     if4.result_margin);
        else passed++;
        // frame_clr alone
        drv4(1, 0, {8'd1, 24'h000001});
        drv4(1, 0, {8'd2, 24'h000002});
        drv4(1, 0, {8'd3, 24'h000003});
        drv4(0, 1, 0);
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL clr_alone got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'hA0, 24'h000400});
        total++;
        if (if4.result_rdy !== 1'b0)
            $display("FAIL clr_alone_next got %b want 0", if4.result_rdy);
        else passed++;
        drv4(1, 0, {8'hA1, 24'h000300});
        drv4(1, 0, {8'hA2, 24'h000350});
        drv4(1, 0, {8'hA3, 24'h000500});
        total++;
        if (if4.result_rdy !== 1'b1 || if4.result_label !== 8'hA1 ||
            if4.result_dist !== 24'h300 || if4.result_margin !== 24'h50)
            $display("FAIL clr_after got %b %h %h %h want 1 a1 300 50",
                     if4.result_rdy, if4.result_label, if4.result_dist,
                     if4.result_margin);
        else passed++;
        drv4(0, 0, 0);
        total++;
        if (p4 - base !== 2)
            $display("FAIL clr_pulses got %0d want 2", p4 - base);
        else passed++;
    endtask

    task automatic test_single_class;
        int base;
        base = p1;
        drv1(1, {8'hA, 24'h000FFF});
        total++;
        if (if1.result_rdy !== 1'b1 || if1.result_label !== 8'hA ||
            if1.result_dist !== 24'hFFF ||
            if1.result_margin !== 24'hFFF000 || if1.result_valid !== 1'b1)
            $display("FAIL nc1 got %b %h %h %h %b want 1 0a fff fff000 1",
                     if1.result_rdy, if1.result_label, if1.result_dist,
                     if1.result_margin, if1.result_valid);
        else passed++;
        drv1(1, {8'hB, 24'hFFFFFF});
        total++;
        if (if1.result_rdy !== 1'b1 || if1.result_label !== 8'hFF ||
            if1.result_margin !== 24'h0 || if1.result_valid !== 1'b0)
            $display("FAIL nc1_reject got %b %h %h %b want 1 ff 0 0",
                     if1.result_rdy, if1.result_label,
                     if1.result_margin, if1.result_valid);
        else passed++;
        drv1(0, 0);
        total++;
        if (if1.result_rdy !== 1'b0 || p1 - base !== 2)
            $display("FAIL nc1_pulses got rdy=%b n=%0d want 0 2",
                     if1.result_rdy, p1 - base);
        else passed++;
    endtask

    initial begin
        if4.data_in = '0;
        if4.data_in_rdy = 1'b0;
        if4.frame_clr = 1'b0;
        if1.data_in = '0;
        if1.data_in_rdy = 1'b0;
        if1.frame_clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_tie_reject();
        test_back_to_back();
        test_frame_clr();
        test_single_class();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
